// File: rtl/i2c_slv_pkg.sv
// ---------------------------------------------------------------------------
// i2c_slv_pkg
// Shared types and constants for the I2C slave register file:
//   - i2c_slv_state_e : protocol state of the slave
//   - i2c_evt_t       : START/STOP bus-condition strobes
//   - I2C_WRITE/READ  : R/W bit values in the address byte
//   - I2C_DEFAULT_ADDR: default 7-bit slave address
//   - maj3()          : 3-input majority vote used by the optional filter
// ---------------------------------------------------------------------------
package i2c_slv_pkg;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h22;
    localparam logic       I2C_WRITE        = 1'b0;
    localparam logic       I2C_READ         = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WR_DATA  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_DATA  = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } i2c_slv_state_e;

    typedef struct packed {
        logic start;
        logic stop;
    } i2c_evt_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_slv_line_cond.sv
// ---------------------------------------------------------------------------
// i2c_slv_line_cond
// Conditions the raw SCL/SDA pins: 2-flop synchronizer per line, optional
// 3-sample majority filter (macro I2C_SLV_GLITCH_FILTER_EN), then edge and
// START/STOP detection on the conditioned levels.
// Ports:
//   i_clk, i_rst    system clock, async active-high reset
//   i_scl, i_sda    raw bus lines
//   o_sda           conditioned SDA level (aligned with the SCL strobes)
//   o_scl_rise/fall single-cycle SCL edge strobes
//   o_evt           single-cycle START/STOP strobes
// Strobes are valid 2 cycles after a pin change (4 with the filter), so the
// consuming state machine reacts on the 3rd (5th) clock edge.
// ---------------------------------------------------------------------------
module i2c_slv_line_cond
    import i2c_slv_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_scl,
    input  logic     i_sda,
    output logic     o_sda,
    output logic     o_scl_rise,
    output logic     o_scl_fall,
    output i2c_evt_t o_evt
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       w_scl;
    logic       w_sda;
    logic       r_scl_d;
    logic       r_sda_d;

    // Two-flop synchronizers; reset to the idle (released) bus level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_filt;
    logic       r_sda_filt;

    // Majority of three consecutive samples: a one-cycle pulse never wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
            r_scl_filt <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
            r_sda_filt <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    // Previous conditioned levels for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign o_sda       = w_sda;
    assign o_scl_rise  = ~r_scl_d & w_scl;
    assign o_scl_fall  = r_scl_d & ~w_scl;
    // SCL must be high on both samples so an SCL edge is never mistaken
    // for a bus condition.
    assign o_evt.start = r_sda_d & ~w_sda & r_scl_d & w_scl;
    assign o_evt.stop  = ~r_sda_d & w_sda & r_scl_d & w_scl;

endmodule

// File: rtl/i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile
// I2C slave answering one 7-bit address, exposing a 2**PTR_WIDTH x byte
// register file with an auto-incrementing pointer. First byte after a write
// address loads the pointer; later bytes are written and reported on
// wr_valid_o. Reads stream mem[ptr] until the master NACKs.
// Ports:
//   clk_i, rst_i   system clock, async active-high reset
//   scl_i, sda_i   bus lines as seen on the wire
//   sda_o          open-drain drive (0 = pull low, 1 = release)
//   busy_o         addressed transfer in progress
//   wr_valid_o     one-cycle pulse per committed byte, with wr_ptr_o/wr_data_o
//   xfer_done_o    one-cycle pulse on STOP ending an addressed transfer
// Build option: define I2C_SLV_GLITCH_FILTER_EN to add the majority filter
// in the line conditioner (event latency 3 -> 5 cycles).
// ---------------------------------------------------------------------------
module i2c_slave_regfile
    import i2c_slv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = I2C_DEFAULT_ADDR,
    parameter int                    PTR_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] RST_FILL   = 8'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  busy_o,
    output logic                  wr_valid_o,
    output logic [PTR_WIDTH-1:0]  wr_ptr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  xfer_done_o
);

    localparam int                DEPTH    = 2 ** PTR_WIDTH;
    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    generate
        if (ADDR_WIDTH != 7 || DATA_WIDTH != ADDR_WIDTH + 1) begin : g_bad_width
            $error("i2c_slave_regfile: ADDR_WIDTH must be 7 and DATA_WIDTH 8");
        end
    endgenerate

    logic           w_sda;
    logic           w_scl_rise;
    logic           w_scl_fall;
    i2c_evt_t       w_evt;

    i2c_slv_state_e r_state, w_state_nx;
    logic [CNT_W-1:0]      r_cnt,     w_cnt_nx;
    logic [DATA_WIDTH-1:0] r_shift,   w_shift_nx;
    logic [PTR_WIDTH-1:0]  r_ptr,     w_ptr_nx;
    logic                  r_sda,     w_sda_nx;
    logic                  r_busy,    w_busy_nx;
    logic                  r_in_ack,  w_in_ack_nx;
    logic                  r_wr_valid, w_wr_valid_nx;
    logic [PTR_WIDTH-1:0]  r_wr_ptr,  w_wr_ptr_nx;
    logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nx;
    logic                  r_xfer_done, w_xfer_done_nx;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_rx_byte;
    logic [DATA_WIDTH-1:0] w_tx_byte;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    i2c_slv_line_cond u_line_cond (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_evt      (w_evt)
    );

    // Next-state and output decode; STOP beats START beats SCL edges.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_shift_nx     = r_shift;
        w_ptr_nx       = r_ptr;
        w_sda_nx       = r_sda;
        w_busy_nx      = r_busy;
        w_in_ack_nx    = r_in_ack;
        w_wr_valid_nx  = 1'b0;
        w_wr_ptr_nx    = r_wr_ptr;
        w_wr_data_nx   = r_wr_data;
        w_xfer_done_nx = 1'b0;
        w_mem_we       = 1'b0;
        w_rx_byte      = {r_shift[DATA_WIDTH-2:0], w_sda};
        w_tx_byte      = r_mem[r_ptr];

        if (w_evt.stop) begin
            w_state_nx     = ST_IDLE;
            w_sda_nx       = 1'b1;
            w_in_ack_nx    = 1'b0;
            w_busy_nx      = 1'b0;
            w_xfer_done_nx = r_busy;
        end else if (w_evt.start) begin
            // Also a repeated START: any partial byte is simply dropped.
            w_state_nx  = ST_ADDR;
            w_sda_nx    = 1'b1;
            w_in_ack_nx = 1'b0;
            w_cnt_nx    = '0;
            w_shift_nx  = '0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nx = w_rx_byte;
                        w_cnt_nx   = r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BIT) begin
                            w_cnt_nx = '0;
                            if (r_state == ST_ADDR) begin
                                w_state_nx = ST_ADDR_ACK;
                            end else if (r_state == ST_PTR) begin
                                w_ptr_nx   = w_rx_byte[PTR_WIDTH-1:0];
                                w_state_nx = ST_PTR_ACK;
                            end else begin
                                w_mem_we      = 1'b1;
                                w_wr_valid_nx = 1'b1;
                                w_wr_ptr_nx   = r_ptr;
                                w_wr_data_nx  = w_rx_byte;
                                w_ptr_nx      = r_ptr + PTR_WIDTH'(1);
                                w_state_nx    = ST_WR_ACK;
                            end
                        end else begin
                            w_state_nx = r_state;
                        end
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                ST_ADDR_ACK: begin
                    // First fall opens the ACK slot, second fall closes it.
                    // r_shift[0] still holds the R/W bit here.
                    if (w_scl_fall) begin
                        if (!r_in_ack) begin
                            if (r_shift[DATA_WIDTH-1:1] == SLAVE_ADDR) begin
                                w_sda_nx    = 1'b0;
                                w_in_ack_nx = 1'b1;
                                w_busy_nx   = 1'b1;
                            end else begin
                                w_state_nx = ST_IGNORE;
                            end
                        end else if (r_shift[0] == I2C_READ) begin
                            w_in_ack_nx = 1'b0;
                            w_shift_nx  = w_tx_byte;
                            w_sda_nx    = w_tx_byte[DATA_WIDTH-1];
                            w_cnt_nx    = '0;
                            w_state_nx  = ST_RD_DATA;
                        end else begin
                            w_in_ack_nx = 1'b0;
                            w_sda_nx    = 1'b1;
                            w_cnt_nx    = '0;
                            w_state_nx  = ST_PTR;
                        end
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                ST_PTR_ACK, ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_in_ack) begin
                            w_sda_nx    = 1'b0;
                            w_in_ack_nx = 1'b1;
                        end else begin
                            w_sda_nx    = 1'b1;
                            w_in_ack_nx = 1'b0;
                            w_cnt_nx    = '0;
                            w_state_nx  = ST_WR_DATA;
                        end
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                ST_RD_DATA: begin
                    // Each fall ends the bit just sampled by the master.
                    if (w_scl_fall) begin
                        if (r_cnt == LAST_BIT) begin
                            w_sda_nx    = 1'b1;
                            w_in_ack_nx = 1'b0;
                            w_ptr_nx    = r_ptr + PTR_WIDTH'(1);
                            w_state_nx  = ST_RD_ACK;
                        end else begin
                            w_shift_nx = {r_shift[DATA_WIDTH-2:0], 1'b0};
                            w_sda_nx   = r_shift[DATA_WIDTH-2];
                            w_cnt_nx   = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                ST_RD_ACK: begin
                    // r_in_ack remembers a master ACK until the next fall.
                    if (w_scl_rise) begin
                        if (w_sda == I2C_WRITE) begin
                            w_in_ack_nx = 1'b1;
                        end else begin
                            w_busy_nx  = 1'b0;
                            w_state_nx = ST_IGNORE;
                        end
                    end else if (w_scl_fall && r_in_ack) begin
                        w_in_ack_nx = 1'b0;
                        w_shift_nx  = w_tx_byte;
                        w_sda_nx    = w_tx_byte[DATA_WIDTH-1];
                        w_cnt_nx    = '0;
                        w_state_nx  = ST_RD_DATA;
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    w_sda_nx = 1'b1;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_sda_nx   = 1'b1;
                end
            endcase
        end
    end

    // Protocol state and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_sda       <= 1'b1;
            r_busy      <= 1'b0;
            r_in_ack    <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_ptr    <= '0;
            r_wr_data   <= '0;
            r_xfer_done <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_shift     <= w_shift_nx;
            r_ptr       <= w_ptr_nx;
            r_sda       <= w_sda_nx;
            r_busy      <= w_busy_nx;
            r_in_ack    <= w_in_ack_nx;
            r_wr_valid  <= w_wr_valid_nx;
            r_wr_ptr    <= w_wr_ptr_nx;
            r_wr_data   <= w_wr_data_nx;
            r_xfer_done <= w_xfer_done_nx;
        end
    end

    // Register file storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RST_FILL;
            end
        end else if (w_mem_we) begin
            r_mem[r_ptr] <= w_rx_byte;
        end
    end

    assign sda_o       = r_sda;
    assign busy_o      = r_busy;
    assign wr_valid_o  = r_wr_valid;
    assign wr_ptr_o    = r_wr_ptr;
    assign wr_data_o   = r_wr_data;
    assign xfer_done_o = r_xfer_done;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regfile
// Bit-banged I2C master driving i2c_slave_regfile through a wired-AND SDA.
// A transaction-level model (register array + pointer + expected write
// event queue) predicts the slave's behaviour; a per-cycle monitor checks
// write events and SDA release against it.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regfile;

    localparam int PH = 5;          // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl;
    logic       m_sda;
    logic       bus_sda;
    logic       sda_o_w;
    logic       busy_w;
    logic       wr_valid_w;
    logic [3:0] wr_ptr_w;
    logic [7:0] wr_data_w;
    logic       xfer_w;

    always #5 clk = ~clk;

    assign bus_sda = m_sda & sda_o_w;

    i2c_slave_regfile dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .scl_i       (m_scl),
        .sda_i       (bus_sda),
        .sda_o       (sda_o_w),
        .busy_o      (busy_w),
        .wr_valid_o  (wr_valid_w),
        .wr_ptr_o    (wr_ptr_w),
        .wr_data_o   (wr_data_w),
        .xfer_done_o (xfer_w)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mdl_mem [16];
    int          mdl_ptr = 0;
    logic [11:0] exp_wr [$];
    int          exp_xfer = 0;
    int          seen_xfer = 0;
    logic        exp_release = 1'b0;
    logic [11:0] cmp_e;
    logic [7:0]  wq [$];
    logic [7:0]  got [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Per-cycle monitor against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid_w) begin
                check("wr_valid expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    cmp_e = exp_wr.pop_front();
                    check("wr event ptr/data", {20'd0, wr_ptr_w, wr_data_w}, {20'd0, cmp_e});
                end
            end
            if (xfer_w) seen_xfer++;
            if (exp_release) check("sda released", 32'(sda_o_w), 32'd1);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period starting and ending with SCL low; returns SDA seen high.
    task automatic bit_xfer(input logic b, output logic r, input logic glitch);
        clks(PH); m_sda = b;
        clks(PH); m_scl = 1'b1;
        if (glitch) begin
            clks(2); m_scl = 1'b0;
            clks(1); m_scl = 1'b1;
            clks(PH - 3);
        end else begin
            clks(PH);
        end
        r = bus_sda;
        clks(PH); m_scl = 1'b0;
    endtask

    task automatic start_cond();
        clks(PH); m_sda = 1'b0;
        clks(PH); m_scl = 1'b0;
    endtask

    task automatic rstart_cond();
        clks(PH); m_sda = 1'b1;
        clks(PH); m_scl = 1'b1;
        clks(PH); m_sda = 1'b0;
        clks(PH); m_scl = 1'b0;
    endtask

    task automatic stop_cond();
        clks(PH); m_sda = 1'b0;
        clks(PH); m_scl = 1'b1;
        clks(PH); m_sda = 1'b1;
        clks(4 * PH);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r, 1'b0);
        bit_xfer(1'b1, r, 1'b0);
        check(nm, 32'(r), 32'(exp_ack));
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r, 1'b0);
            b[i] = r;
        end
        bit_xfer(nack, r, 1'b0);
    endtask

    task automatic end_checks(input string nm);
        check({nm, " busy low"}, 32'(busy_w), 32'd0);
        check({nm, " xfer_done count"}, 32'(seen_xfer), 32'(exp_xfer));
        check({nm, " pending writes"}, 32'(exp_wr.size()), 32'd0);
    endtask

    // Full write transaction: pointer byte then the bytes in wq.
    task automatic wr_txn(input logic [7:0] ptr_b);
        start_cond();
        send_byte(8'h44, 1'b0, "wr addr ack");
        check("busy after addr", 32'(busy_w), 32'd1);
        send_byte(ptr_b, 1'b0, "ptr ack");
        mdl_ptr = int'(ptr_b) % 16;
        foreach (wq[k]) begin
            exp_wr.push_back({4'(mdl_ptr), wq[k]});
            mdl_mem[mdl_ptr] = wq[k];
            mdl_ptr = (mdl_ptr + 1) % 16;
            send_byte(wq[k], 1'b0, "data ack");
        end
        stop_cond();
        exp_xfer++;
        end_checks("wr_txn");
    endtask

    // Set pointer, repeated START, read n bytes (last one NACKed) into got.
    task automatic rd_txn(input logic [7:0] ptr_b, input int n);
        logic [7:0] b;
        got.delete();
        start_cond();
        send_byte(8'h44, 1'b0, "rd setup addr ack");
        send_byte(ptr_b, 1'b0, "rd setup ptr ack");
        mdl_ptr = int'(ptr_b) % 16;
        rstart_cond();
        send_byte(8'h45, 1'b0, "rd addr ack");
        check("busy in read", 32'(busy_w), 32'd1);
        for (int k = 0; k < n; k++) begin
            recv_byte(b, k == n - 1);
            check("rd data vs model", 32'(b), 32'(mdl_mem[mdl_ptr]));
            mdl_ptr = (mdl_ptr + 1) % 16;
            got.push_back(b);
        end
        clks(2 * PH);
        check("busy after nack", 32'(busy_w), 32'd0);
        check("sda released after nack", 32'(sda_o_w), 32'd1);
        stop_cond();
        end_checks("rd_txn");
    endtask

    initial begin
        logic r;
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        clks(4);
        check("reset sda_o", 32'(sda_o_w), 32'd1);
        check("reset busy_o", 32'(busy_w), 32'd0);
        check("reset wr_valid_o", 32'(wr_valid_w), 32'd0);
        check("reset wr_ptr_o", 32'(wr_ptr_w), 32'd0);
        check("reset wr_data_o", 32'(wr_data_w), 32'd0);
        check("reset xfer_done_o", 32'(xfer_w), 32'd0);
        rst = 1'b0;
        clks(10);

        // 1: write ptr 3, A5, 5A
        wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h5A);
        wr_txn(8'h03);
        check("model pin mem[3]", 32'(mdl_mem[3]), 32'hA5);

        // 2: read back two bytes
        rd_txn(8'h03, 2);
        check("rd byte0 literal", 32'(got[0]), 32'hA5);
        check("rd byte1 literal", 32'(got[1]), 32'h5A);

        // 3: wrong address is ignored entirely
        exp_release = 1'b1;
        start_cond();
        send_byte(8'h46, 1'b1, "bad addr nack");
        check("busy bad addr", 32'(busy_w), 32'd0);
        send_byte(8'h12, 1'b1, "ignored data nack");
        stop_cond();
        exp_release = 1'b0;
        end_checks("bad addr");

        // 4: pointer wrap 15 -> 0, upper pointer bits ignored on read
        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
        wr_txn(8'h0F);
        rd_txn(8'h30, 1);
        check("wrap read literal", 32'(got[0]), 32'h22);

        // 5: STOP after 4 bits discards the byte
        start_cond();
        send_byte(8'h44, 1'b0, "partial addr ack");
        send_byte(8'h03, 1'b0, "partial ptr ack");
        mdl_ptr = 3;
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, r, 1'b0);
        stop_cond();
        exp_xfer++;
        end_checks("partial");
        rd_txn(8'h03, 1);
        check("partial keeps prior", 32'(got[0]), 32'hA5);

        // 6: reset while the slave drives ACK
        start_cond();
        for (int i = 7; i >= 0; i--) bit_xfer(8'h44 >> i, r, 1'b0);
        for (int i = 0; i < 4 * PH && sda_o_w; i++) clks(1);
        check("ack driven before reset", 32'(sda_o_w), 32'd0);
        rst = 1'b1;
        #1;
        check("sda released by reset", 32'(sda_o_w), 32'd1);
        check("busy cleared by reset", 32'(busy_w), 32'd0);
        clks(3); m_scl = 1'b1; m_sda = 1'b1;
        clks(3); rst = 1'b0;
        clks(10);
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
        rd_txn(8'h03, 2);
        check("post-reset fill literal", 32'(got[0]), 32'h00);

`ifdef I2C_SLV_GLITCH_FILTER_EN
        // Single-cycle SCL low pulse inside a high phase must not shift a bit.
        start_cond();
        for (int i = 7; i >= 0; i--) bit_xfer(8'h44 >> i, r, i == 5);
        bit_xfer(1'b1, r, 1'b0);
        check("glitch addr ack", 32'(r), 32'd0);
        stop_cond();
        exp_xfer++;
        end_checks("glitch");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
Synthesizable I2C slave sitting directly downstream of the I2C multi-bus controller, on one bus (scl_o/sda_o of the master drive this block's inputs). Responds to one 7-bit address and exposes a byte-wide register file with an auto-incrementing pointer. Serves as a deterministic RTL responder for system-level runs alongside the I2C BFM, and publishes write and transfer events for scoreboards.

Parameters:
ADDR_WIDTH, 7, I2C address width (fixed 7; checked at elaboration)
DATA_WIDTH, 8, byte width on the bus
SLAVE_ADDR, 7'h22, address this slave answers
PTR_WIDTH, 4, register pointer width; depth = 2**PTR_WIDTH
RST_FILL, 8'h00, reset value of every register

Ports:
clk_i  in  1  system clock (same clock as the Wishbone side)
rst_i  in  1  asynchronous active-high reset
scl_i  in  1  I2C clock line, as seen on the bus
sda_i  in  1  I2C data line, as seen on the bus
sda_o  out 1  open-drain data drive; 0 = pull low, 1 = release
busy_o  out 1  high from an addressed START until STOP or NACK
wr_valid_o  out 1  one-cycle pulse when a data byte is committed
wr_ptr_o  out PTR_WIDTH  register index of the committed byte
wr_data_o  out DATA_WIDTH  committed byte
xfer_done_o  out 1  one-cycle pulse on STOP ending an addressed transfer

Behaviour:
- Reset (asynchronous): sda_o=1, busy_o=0, wr_valid_o=0, wr_ptr_o=0, wr_data_o=0, xfer_done_o=0, pointer=0, all registers=RST_FILL, state=IDLE. Asserting reset mid-transfer releases sda on the same edge.
- Input path: scl_i and sda_i each pass through a 2-flop synchronizer. Edges are detected on the synchronized values. Event latency is 3 clk_i cycles from the pin.
- START: sda falls while scl is high. Enters ADDR from any state; this also covers repeated START. STOP: sda rises while scl is high. Enters IDLE from any state.
- Bit sampling: on the scl rising edge. Drive changes: in the cycle after an scl falling edge is detected.
- States:
  - IDLE
  - ADDR: shift in 8 bits, MSB first.
  - ADDR_ACK: drive 0 if address == SLAVE_ADDR, else go to IGNORE.
  - PTR: first byte after a write address loads the pointer (low PTR_WIDTH bits; upper bits ignored).
  - PTR_ACK
  - WR_DATA
  - WR_ACK
  - RD_DATA: drive mem[ptr] MSB first.
  - RD_ACK: release sda and sample the master's ACK.
  - IGNORE: sda released until START/STOP.
- Write commit: on the 8th rising edge in WR_DATA, write mem[ptr], pulse wr_valid_o with ptr/data, then ptr <= ptr+1 (wraps modulo depth). The ACK is then driven.
- Read: ptr increments after each byte is transmitted. On master ACK (0), load the next byte. On NACK (1), go to IGNORE and clear busy_o.
- A STOP or START mid-byte discards the partial byte: no commit, no pointer change.
- xfer_done_o pulses only if busy_o was high at the STOP.
- sda_o is released in every state except the ACK slots and RD_DATA zero bits.
- The slave never stretches scl.

Optional Feature:
I2C_SLV_GLITCH_FILTER_EN:
- Defined: a 3-sample majority filter follows each synchronizer. Event latency becomes 5 cycles, and single-cycle pulses on scl/sda are suppressed.
- Undefined: synchronizer only, with 3-cycle latency. A 1-cycle glitch on scl is treated as a real edge.

Decomposition:
- Package i2c_slv_pkg: the state enum, START/STOP event typedef, R/W bit constants (I2C_WRITE=0, I2C_READ=1), and the default address constant.
- One sub-module, i2c_slv_line_cond: synchronizer, optional filter, and edge/START/STOP detection. It is instantiated once and produces scl_rise, scl_fall, start, stop strobes.
- The register file is an inferred array inside the top.

Test Plan:
1. Write addr 0x22, ptr 0x03, data 0xA5, 0x5A, STOP -> ACK on all 4 bytes. wr_valid_o pulses twice: (3,0xA5) then (4,0x5A). One xfer_done_o pulse.
2. Write ptr 0x03, repeated START, read 2 bytes, ACK then NACK -> slave returns 0xA5, 0x5A. busy_o drops after the NACK. sda_o released.
3. Address 0x23 -> no ACK (sda_o stays 1), busy_o stays 0, no wr_valid_o, no xfer_done_o.
4. Pointer 0x0F, write 0x11, 0x22 -> commits at 15 then 0 (wrap). Reading from ptr 0 returns 0x22.
5. STOP after 4 bits of a data byte -> no commit. A later read of that index returns the prior value.
6. rst_i asserted while slave drives ACK -> sda_o=1 immediately. Registers read back RST_FILL. With I2C_SLV_GLITCH_FILTER_EN, a 1-cycle scl low pulse produces no bit shift.
